// File: rtl/i2c_slave_word_regs_pkg.sv
// Shared definitions for the I2C word-register slave: FSM encoding, register map,
// default device address and the byte-lane selector used on the read path.
package i2c_slave_word_regs_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StDevAck,
        StRegAddr,
        StRegAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck
    } state_e;

    localparam logic [7:0] RegAddr0       = 8'h00;
    localparam logic [7:0] RegAddr1       = 8'h04;
    localparam logic [6:0] DefaultI2cAddr = 7'h3C;

    // Byte index 0 is the most significant byte of the word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/i2c_slave_word_regs_in_filter.sv
// Two-flop synchronizer followed by a debounce filter: the output only takes a new level
// after DEB_LEN consecutive synchronized samples agree on it.
module i2c_in_filter #(
    parameter int unsigned DEB_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic out_o
);
    localparam int unsigned CntW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

    logic [1:0]      sync_q;
    logic            out_q, out_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            out_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], in_i};
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        if (sync_q[1] != out_q) begin
            if (cnt_q == CntW'(DEB_LEN - 1)) begin
                out_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/i2c_slave_word_regs.sv
// I2C slave exposing two 32-bit registers at 8'h00 and 8'h04, written and read
// MSB-byte first with an auto-advancing word pointer.
module i2c_slave_word_regs
    import i2c_slave_word_regs_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDRESS = DefaultI2cAddr,
    parameter int unsigned DEB_LEN     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [31:0] reg0_o,
    output logic [31:0] reg1_o,
    output logic        wr_stb,
    output logic [7:0]  wr_addr
);
    logic scl_f, sda_f, scl_prev_q, sda_prev_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        rw_q, rw_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] stage_q, stage_d;
    logic [7:0]  rd_sh_q, rd_sh_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic [31:0] reg0_q, reg0_d, reg1_q, reg1_d;
    logic        wr_stb_q, wr_stb_d;
    logic [7:0]  wr_addr_q, wr_addr_d;

    logic        byte_done, addr_match;
    logic [31:0] rd_word, wr_word;
    logic [7:0]  rd_byte;

    i2c_in_filter #(.DEB_LEN(DEB_LEN)) u_scl_filter (
        .clk_i (clk),
        .rst_ni(rst_n),
        .in_i  (scl_in),
        .out_o (scl_f)
    );

    i2c_in_filter #(.DEB_LEN(DEB_LEN)) u_sda_filter (
        .clk_i (clk),
        .rst_ni(rst_n),
        .in_i  (sda_in),
        .out_o (sda_f)
    );

    assign scl_rise   = scl_f && !scl_prev_q;
    assign scl_fall   = !scl_f && scl_prev_q;
    assign start_det  = scl_f && scl_prev_q && sda_prev_q && !sda_f;
    assign stop_det   = scl_f && scl_prev_q && !sda_prev_q && sda_f;
    assign byte_done  = (bit_cnt_q == 4'd8);
    assign addr_match = (shreg_q[7:1] == I2C_ADDRESS);
    assign wr_word    = {stage_q, shreg_q};
    assign rd_word    = (ptr_q == RegAddr0) ? reg0_q :
                        (ptr_q == RegAddr1) ? reg1_q : 32'h0;
    assign rd_byte    = word_byte(rd_word, idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= 8'h00;
            idx_q      <= '0;
            stage_q    <= '0;
            rd_sh_q    <= '0;
            mack_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            reg0_q     <= '0;
            reg1_q     <= '0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 8'h00;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            rd_sh_q    <= rd_sh_d;
            mack_q     <= mack_d;
            sda_oe_q   <= sda_oe_d;
            reg0_q     <= reg0_d;
            reg1_q     <= reg1_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    // Bits are taken on SCL rise; byte-level decisions happen on the SCL fall after bit 8.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        rd_sh_d   = rd_sh_q;
        mack_d    = mack_q;
        reg0_d    = reg0_q;
        reg1_d    = reg1_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            idx_d     = '0;
        end else if (start_det) begin
            state_d   = StDevAddr;
            bit_cnt_d = '0;
            idx_d     = '0;
        end else begin
            unique case (state_q)
                StDevAddr, StRegAddr, StWrByte: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        bit_cnt_d = '0;
                        if (state_q == StDevAddr) begin
                            rw_d    = shreg_q[0];
                            state_d = addr_match ? StDevAck : StIdle;
                        end else if (state_q == StRegAddr) begin
                            ptr_d   = shreg_q;
                            idx_d   = '0;
                            state_d = StRegAck;
                        end else begin
                            stage_d = {stage_q[15:0], shreg_q};
                            state_d = StWrAck;
                            if (idx_q == 2'd3) begin
                                if (ptr_q == RegAddr0) reg0_d = wr_word;
                                if (ptr_q == RegAddr1) reg1_d = wr_word;
                                if (ptr_q == RegAddr0 || ptr_q == RegAddr1) begin
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = ptr_q;
                                end
                                ptr_d = ptr_q + 8'd4;
                                idx_d = '0;
                            end else begin
                                idx_d = idx_q + 2'd1;
                            end
                        end
                    end
                end
                StDevAck: begin
                    if (scl_fall) begin
                        state_d = rw_q ? StRdByte : StRegAddr;
                        rd_sh_d = rd_byte;
                    end
                end
                StRegAck, StWrAck: begin
                    if (scl_fall) state_d = StWrByte;
                end
                StRdByte: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            bit_cnt_d = '0;
                            state_d   = StRdAck;
                            idx_d     = idx_q + 2'd1;
                            if (idx_q == 2'd3) ptr_d = ptr_q + 8'd4;
                        end else begin
                            rd_sh_d = {rd_sh_q[6:0], 1'b0};
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        mack_d = !sda_f;
                    end else if (scl_fall) begin
                        state_d = mack_q ? StRdByte : StIdle;
                        rd_sh_d = rd_byte;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // SDA drive only moves on an SCL fall, so it can never fake a START or STOP.
    always_comb begin
        sda_oe_d = sda_oe_q;
        if (start_det || stop_det) begin
            sda_oe_d = 1'b0;
        end else if (scl_fall) begin
            unique case (state_q)
                StDevAddr:           sda_oe_d = byte_done && addr_match;
                StRegAddr, StWrByte: sda_oe_d = byte_done;
                StDevAck:            sda_oe_d = rw_q && !rd_byte[7];
                StRdByte:            sda_oe_d = !byte_done && !rd_sh_q[6];
                StRdAck:             sda_oe_d = mack_q && !rd_byte[7];
                default:             sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe  = sda_oe_q;
    assign reg0_o  = reg0_q;
    assign reg1_o  = reg1_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;

endmodule

// File: doc/i2c_slave_word_regs.md
I2C_SLAVE_WORD_REGS -- requirements
Module: i2c_slave_word_regs

Interface
REQ-001 Parameter I2C_ADDRESS, default 7'h3C, the 7-bit slave address this block answers to.
REQ-002 Parameter DEB_LEN, default 3, the number of consecutive equal clk samples needed to accept a new SCL/SDA level.
REQ-003 clk  input  1  single system clock (125 MHz nominal); all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 scl_in  input  1  I2C SCL pad input, asynchronous to clk.
REQ-006 sda_in  input  1  I2C SDA pad input, asynchronous to clk.
REQ-007 sda_oe  output  1  when 1, the pad drives SDA low; when 0, SDA is released (open-drain).
REQ-008 reg0_o  output  32  word register at register address 8'h00.
REQ-009 reg1_o  output  32  word register at register address 8'h04.
REQ-010 wr_stb  output  1  single-cycle pulse when a 32-bit word is committed.
REQ-011 wr_addr  output  8  register address of the committed word; valid while wr_stb=1.

Function
REQ-012 scl_in and sda_in shall each pass a 2-flop synchronizer and then a DEB_LEN-sample debounce filter; all protocol decisions use the filtered signals only.
REQ-013 START is filtered SDA falling while filtered SCL=1; STOP is filtered SDA rising while filtered SCL=1; both are detected in every state.
REQ-014 FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-015 START (including repeated START) -> DEV_ADDR with the bit counter cleared; STOP -> IDLE with sda_oe=0 from any state.
REQ-016 Bits are sampled on filtered SCL rising edges, MSB first; sda_oe changes only on the clk cycle after a filtered SCL falling edge.
REQ-017 DEV_ADDR: if the 7 received address bits match I2C_ADDRESS -> DEV_ACK and drive ACK; on mismatch -> IDLE, SDA never driven.
REQ-018 After DEV_ACK: R/W=0 -> REG_ADDR; R/W=1 -> RD_BYTE, reading from the current register pointer.
REQ-019 REG_ADDR: the received byte loads the register pointer and clears the byte index to 0; always ACKed.
REQ-020 WR_BYTE: data bytes shift into a 32-bit staging word MSB-first (the first byte becomes bits 31:24); every byte is ACKed.
REQ-021 On the 4th byte of a word: if the pointer is 8'h00 or 8'h04, the target register updates and wr_stb pulses for 1 clk, with wr_addr = pointer; the pointer then advances by 4 and the byte index returns to 0.
REQ-022 A write to any other pointer value is ACKed but discarded (no wr_stb); a pointer advance from 8'hFC wraps to 8'h00.
REQ-023 A partial word (<4 bytes) ended by STOP or START shall be discarded; the registers stay unchanged.
REQ-024 RD_BYTE shifts out the selected register byte by byte, MSB first (byte index 0 = bits 31:24); unmapped pointers read 8'h00.
REQ-025 RD_ACK: master ACK -> next byte, with the pointer advancing by 4 after 4 bytes; master NACK -> SDA released, wait for STOP/START.
REQ-026 A write and a read in the same clk cannot collide: register updates happen only in WR_BYTE.

Reset
REQ-027 Reset values: sda_oe=0, reg0_o=32'h0, reg1_o=32'h0, wr_stb=0, wr_addr=8'h00, pointer=8'h00, FSM=IDLE, synchronizers and filters=1.
REQ-028 Reset asserted mid-transfer shall abort the transfer immediately and release SDA asynchronously.

Structure
REQ-029 FSM state encoding, register address constants (8'h00, 8'h04) and the default I2C_ADDRESS shall live in a shared package.
REQ-030 The synchronizer plus debounce shall be a sub-module i2c_in_filter, instantiated once per line.

Verification
REQ-031 Write to addr 3C, reg 04, data 05323232, STOP -> reg1_o=32'h05323232; one wr_stb with wr_addr=8'h04; ACK on all 6 bytes.
REQ-032 Write to reg 00, data 0000C789, then 0100C789 -> reg0_o ends at 32'h0100C789; exactly two wr_stb pulses.
REQ-033 Write reg 04, repeated START, read 4 bytes with NACK on the last -> bytes 05,32,32,32 returned MSB first.
REQ-034 Address 3D (mismatch) -> SDA never driven; registers unchanged.
REQ-035 Write reg 00 with 2 bytes, then STOP -> reg0_o unchanged; no wr_stb.
REQ-036 Write reg 00 with 8 bytes 11223344 55667788 -> reg0_o=32'h11223344, reg1_o=32'h55667788 (pointer auto-advance).
